// File: rtl/axi_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : ADAM_SEQ
// Brief    : Clock/reset bundle; rst is asynchronous active-low (0 = reset).
// Revision : 1.0
// ============================================================================
interface ADAM_SEQ;
    logic clk;
    logic rst;

    modport Master (output clk, output rst);
    modport Slave  (input  clk, input  rst);
endinterface
`default_nettype wire

// File: rtl/axi_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_queue
// Brief    : Circular write-command queue feeding an AXI-Lite write stage
//            through a two-state req/ack issue FSM.
// Revision : 1.0
// ============================================================================
module axi_write_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    ADAM_SEQ.Slave                   seq_port,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [ADDR_W-1:0]        push_adress_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     flush_i,
    output logic                     fsm_req_o,
    output logic [ADDR_W-1:0]        fsm_adress_o,
    output logic [DATA_W-1:0]        fsm_data_o,
    input  logic                     fsm_ack_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     overflow_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic [ADDR_W-1:0]   r_head_addr;
    logic [DATA_W-1:0]   r_head_data;
    logic [ADDR_W-1:0]   r_mem_addr [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    // Readiness uses registered occupancy only: a pop in the same cycle
    // never frees a slot for a push while full.
    assign w_full       = (r_count == c_CNT_FULL);
    assign push_ready_o = !w_full && !flush_i;
    assign w_push       = push_valid_i && push_ready_o;
    assign w_pop        = (r_state == ST_REQ) && fsm_ack_i && !flush_i;

    assign fsm_req_o    = (r_state == ST_REQ);
    assign fsm_adress_o = r_head_addr;
    assign fsm_data_o   = r_head_data;
    assign count_o      = r_count;
    assign empty_o      = (r_count == '0);
    assign full_o       = w_full;
    assign overflow_o   = r_overflow;

    always_ff @(posedge seq_port.clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= push_adress_i;
            r_mem_data[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge seq_port.clk or negedge seq_port.rst) begin
        if (!seq_port.rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_head_addr <= '0;
            r_head_data <= '0;
        end else if (flush_i) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (push_valid_i && !push_ready_o) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            // Head is latched on entry to REQ so it stays frozen for the
            // whole request and keeps its last value while idle.
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= ST_REQ;
                        r_head_addr <= r_mem_addr[r_rd_ptr];
                        r_head_data <= r_mem_data[r_rd_ptr];
                    end
                end
                ST_REQ: begin
                    if (fsm_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_write_queue
// Brief    : Self-checking bench: directed vector table, async-reset sequence,
//            and randomized traffic against a queue-level reference model.
// Revision : 1.0
// ============================================================================
module tb_axi_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_addr = '0;
    logic [31:0] push_data = '0;
    logic        flush = 1'b0;
    logic        fsm_req;
    logic [31:0] fsm_addr;
    logic [31:0] fsm_data;
    logic        fsm_ack = 1'b0;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    ADAM_SEQ seq_if ();
    assign seq_if.clk = clk;
    assign seq_if.rst = rst_n;

    always #5 clk = ~clk;

    axi_write_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .seq_port      (seq_if),
        .push_valid_i  (push_valid),
        .push_ready_o  (push_ready),
        .push_adress_i (push_addr),
        .push_data_i   (push_data),
        .flush_i       (flush),
        .fsm_req_o     (fsm_req),
        .fsm_adress_o  (fsm_addr),
        .fsm_data_o    (fsm_data),
        .fsm_ack_i     (fsm_ack),
        .count_o       (count),
        .empty_o       (empty),
        .full_o        (full),
        .overflow_o    (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fl;
        logic        ack;
        logic        e_req;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic        e_rdy;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(logic pv, logic [31:0] a, logic [31:0] d, logic fl, logic ack,
                                logic e_req, logic [2:0] e_cnt, logic e_ovf, logic e_rdy,
                                logic [31:0] e_a, logic [31:0] e_d);
        vec_t v;
        v.pv = pv; v.addr = a; v.data = d; v.fl = fl; v.ack = ack;
        v.e_req = e_req; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_rdy = e_rdy;
        v.e_addr = e_a; v.e_data = e_d;
        return v;
    endfunction

    // Reference model state: the queue contents in order, plus request flag.
    logic [63:0] mq[$];
    logic        m_req  = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [63:0] m_head = '0;
    int          ack_wait = 0;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[26];
        bit   seen;

        // Single write, fill/overflow/drain, simultaneous push+ack,
        // flush during REQ with stray ack, flush overriding a push.
        tbl[0]  = mk(1, 32'h1000, 32'hCAFE, 0, 0, 0, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h1000, 32'hCAFE);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 32'h2000, 32'h11, 0, 0, 0, 1, 0, 1, 0, 0);
        tbl[4]  = mk(1, 32'h2004, 32'h22, 0, 0, 1, 2, 0, 1, 32'h2000, 32'h11);
        tbl[5]  = mk(1, 32'h2008, 32'h33, 0, 0, 1, 3, 0, 1, 32'h2000, 32'h11);
        tbl[6]  = mk(1, 32'h200C, 32'h44, 0, 0, 1, 4, 0, 0, 32'h2000, 32'h11);
        tbl[7]  = mk(1, 32'h2010, 32'h55, 0, 0, 1, 4, 1, 0, 32'h2000, 32'h11);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 3, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 3, 1, 1, 32'h2004, 32'h22);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 2, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 2, 1, 1, 32'h2008, 32'h33);
        tbl[12] = mk(1, 32'h3000, 32'h66, 0, 1, 0, 2, 1, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 2, 1, 1, 32'h200C, 32'h44);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h3000, 32'h66);
        tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        tbl[18] = mk(1, 32'h4000, 32'h77, 0, 0, 0, 1, 1, 1, 0, 0);
        tbl[19] = mk(1, 32'h4004, 32'h88, 0, 0, 1, 2, 1, 1, 32'h4000, 32'h77);
        tbl[20] = mk(1, 32'h4008, 32'h99, 0, 0, 1, 3, 1, 1, 32'h4000, 32'h77);
        tbl[21] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[24] = mk(1, 32'h5000, 32'hAB, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset state, observed while reset is held and after release.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",   fsm_req,  0);
        check("rst_count", count,    0);
        check("rst_empty", empty,    1);
        check("rst_full",  full,     0);
        check("rst_ovf",   overflow, 0);
        check("rst_addr",  fsm_addr, 0);
        check("rst_data",  fsm_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", push_ready, 1);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            push_valid = tbl[i].pv;
            push_addr  = tbl[i].addr;
            push_data  = tbl[i].data;
            flush      = tbl[i].fl;
            fsm_ack    = tbl[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i),   fsm_req,    tbl[i].e_req);
            check($sformatf("vec%0d_count", i), count,      tbl[i].e_cnt);
            check($sformatf("vec%0d_empty", i), empty,      tbl[i].e_cnt == 0);
            check($sformatf("vec%0d_full", i),  full,       tbl[i].e_cnt == 3'(DEPTH));
            check($sformatf("vec%0d_ovf", i),   overflow,   tbl[i].e_ovf);
            check($sformatf("vec%0d_ready", i), push_ready, tbl[i].e_rdy);
            if (tbl[i].e_req) begin
                check($sformatf("vec%0d_addr", i), fsm_addr, tbl[i].e_addr);
                check($sformatf("vec%0d_data", i), fsm_data, tbl[i].e_data);
            end
        end
        @(negedge clk);
        push_valid = 0; flush = 0; fsm_ack = 0;

        // Async reset asserted mid-cycle while a request is outstanding.
        push_valid = 1; push_addr = 32'h6000; push_data = 32'hAA;
        @(negedge clk);
        push_addr = 32'h6004; push_data = 32'hBB;
        @(negedge clk);
        push_valid = 0;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (fsm_req) seen = 1;
            else @(negedge clk);
        end
        check("arst_req_seen", seen, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_req",   fsm_req,  0);
        check("arst_count", count,    0);
        check("arst_empty", empty,    1);
        check("arst_full",  full,     0);
        check("arst_ovf",   overflow, 0);
        check("arst_addr",  fsm_addr, 0);
        check("arst_data",  fsm_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_ready", push_ready, 1);
        fsm_ack = 1;
        @(posedge clk);
        #1;
        check("arst_stale_count", count, 0);
        check("arst_stale_req",   fsm_req, 0);
        @(negedge clk);
        fsm_ack = 0;
        @(posedge clk);
        #1;
        check("arst_idle_req", fsm_req, 0);

        // Randomized traffic; first half without flush so entries wrap
        // through the buffer many times under varying ack delays.
        for (int cyc = 0; cyc < 600; cyc++) begin
            int sz;
            bit m_rdy;
            bit do_pop;
            @(negedge clk);
            push_valid = ($urandom_range(0, 99) < 60);
            push_addr  = $urandom;
            push_data  = $urandom;
            flush      = (cyc >= 300) && ($urandom_range(0, 99) < 4);
            if (m_req) begin
                if (ack_wait == 0) fsm_ack = 1;
                else begin
                    fsm_ack = 0;
                    ack_wait--;
                end
            end else begin
                fsm_ack = ($urandom_range(0, 99) < 5);
            end
            if (m_req && fsm_ack && !flush) begin
                check("rnd_pop_addr", fsm_addr, mq[0][63:32]);
                check("rnd_pop_data", fsm_data, mq[0][31:0]);
            end

            @(posedge clk);
            sz    = mq.size();
            m_rdy = (sz < DEPTH) && !flush;
            if (flush) begin
                mq.delete();
                m_req = 0;
                m_ovf = 0;
            end else begin
                if (push_valid && !m_rdy) m_ovf = 1;
                do_pop = m_req && fsm_ack;
                if (m_req) begin
                    if (fsm_ack) m_req = 0;
                end else if (sz != 0) begin
                    m_req    = 1;
                    m_head   = mq[0];
                    ack_wait = $urandom_range(0, 5);
                end
                if (do_pop) void'(mq.pop_front());
                if (push_valid && m_rdy) mq.push_back({push_addr, push_data});
            end
            #1;
            check("rnd_count", count, mq.size());
            check("rnd_bound", count <= 3'(DEPTH), 1);
            check("rnd_req",   fsm_req, m_req);
            check("rnd_ovf",   overflow, m_ovf);
            check("rnd_empty", empty, mq.size() == 0);
            check("rnd_full",  full, mq.size() == DEPTH);
            check("rnd_ready", push_ready, (mq.size() < DEPTH) && !flush);
            check("rnd_head",  {fsm_addr, fsm_data}, m_head);
        end
        @(negedge clk);
        push_valid = 0; flush = 0; fsm_ack = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
